// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Bit counter must index 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             br_r;
    logic [WIDTH-2:0] work_r;
    logic [WIDTH-1:0] work_nxt_s;
    logic             d_s;
    logic             bnext_s;
    logic             load_s;
    logic             last_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;

    full_subtractor u_cell (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (bnext_s)
    );

    // Load/finish strobes and the working register with the new bit prepended at the MSB.
    always_comb begin
        load_s     = (state_r == IDLE) && start;
        last_s     = (state_r == RUN) && (cnt_r == LAST_CNT);
        work_nxt_s = {d_s, work_r};
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = RUN;
                else       state_nxt_s = IDLE;
            end
            RUN: begin
                if (cnt_r == LAST_CNT) state_nxt_s = DONE;
                else                   state_nxt_s = RUN;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Datapath: operand shifters, borrow, bit counter, result and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            a_sh_r <= '0;
            b_sh_r <= '0;
            br_r   <= 1'b0;
            work_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            done_r <= (state_nxt_s == DONE);
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        a_sh_r <= a;
                        b_sh_r <= b;
                        br_r   <= bin;
                        cnt_r  <= '0;
                    end
                end
                RUN: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    br_r   <= bnext_s;
                    work_r <= work_nxt_s[WIDTH-1:1];
                    if (last_s) begin
                        // Clear rather than wrap so the count stays in range between operations.
                        cnt_r  <= '0;
                        diff_r <= work_nxt_s;
                        bout_r <= bnext_s;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic sa_r;
    logic sb_r;
    logic ovf_r;

    // Operand sign capture and signed-overflow result, updated only when a result completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_r  <= 1'b0;
            sb_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            if (load_s) begin
                sa_r <= a[WIDTH-1];
                sb_r <= b[WIDTH-1];
            end
            if (last_s) begin
                ovf_r <= (sa_r != sb_r) && (d_s != sa_r);
            end
        end
    end

    assign ovf = ovf_r;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 directed/random/handshake scenarios and WIDTH=4 exhaustive.
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;
    int         checks = 0;
    int         errors = 0;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf4;
`endif

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    // Reference model: plain integer arithmetic.
    function automatic int mdl_diff(input int a, input int b, input int bin, input int w);
        return (a - b - bin) & ((1 << w) - 1);
    endfunction

    function automatic int mdl_bout(input int a, input int b, input int bin);
        return (a < b + bin) ? 1 : 0;
    endfunction

    function automatic int mdl_ovf(input int a, input int b, input int bin, input int w);
        int sa, sb, r;
        sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        r  = sa - sb - bin;
        return ((r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1)) ? 1 : 0;
    endfunction

    // Launch one WIDTH=8 operation from a negedge and wait (bounded) for done.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output logic [7:0] d, output logic bo, output logic ov,
                          output int lat, output int bcnt, output logic busy_after);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = -1; bcnt = 0; d = 8'hxx; bo = 1'bx; ov = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (busy8) bcnt++;
            if (done8) begin
                lat = k; d = diff8; bo = bout8;
`ifdef SERIAL_SUB_OVF_EN
                ov = ovf8;
`endif
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        busy_after = busy8;
    endtask

    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          output logic [3:0] d, output logic bo, output logic ov, output int lat);
        a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = -1; d = 4'hx; bo = 1'bx; ov = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done4) begin
                lat = k; d = diff4; bo = bout4;
`ifdef SERIAL_SUB_OVF_EN
                ov = ovf4;
`endif
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic ov;
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
        start4 = 1'b0; a4 = 4'h0;  b4 = 4'h0;  bin4 = 1'b0;
        repeat (3) @(negedge clk);
        ov = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ov = ovf8 | ovf4;
`endif
        checks++;
        if ({busy8, done8, diff8, bout8, ov} !== 12'h000) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b diff=%h bout=%b ovf=%b required all 0", busy8, done8, diff8, bout8, ov);
        end
        checks++;
        if ({busy4, done4, diff4, bout4} !== 7'h00) begin
            errors++;
            $display("FAIL reset4 got busy=%b done=%b diff=%h bout=%b required all 0", busy4, done4, diff4, bout4);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed8();
        logic [7:0] d; logic bo, ov, ba; int lat, bcnt;
        do_op8(8'h35, 8'h12, 1'b0, d, bo, ov, lat, bcnt, ba);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL latency got %0d required 8", lat); end
        checks++;
        if (bcnt !== 9) begin errors++; $display("FAIL busy_len got %0d required 9", bcnt); end
        checks++;
        if (ba !== 1'b0) begin errors++; $display("FAIL busy_fall got %b required 0", ba); end
        checks++;
        if ({d, bo} !== {8'h23, 1'b0}) begin errors++; $display("FAIL d35_12 got %h/%b required 23/0", d, bo); end
        do_op8(8'h00, 8'h01, 1'b0, d, bo, ov, lat, bcnt, ba);
        checks++;
        if ({d, bo} !== {8'hFF, 1'b1}) begin errors++; $display("FAIL d00_01 got %h/%b required ff/1", d, bo); end
        do_op8(8'h10, 8'h0F, 1'b1, d, bo, ov, lat, bcnt, ba);
        checks++;
        if ({d, bo} !== {8'h00, 1'b0}) begin errors++; $display("FAIL d10_0f_b got %h/%b required 00/0", d, bo); end
        do_op8(8'h5A, 8'h5A, 1'b1, d, bo, ov, lat, bcnt, ba);
        checks++;
        if ({d, bo} !== {8'hFF, 1'b1}) begin errors++; $display("FAIL eq_bin got %h/%b required ff/1", d, bo); end
`ifdef SERIAL_SUB_OVF_EN
        do_op8(8'h80, 8'h01, 1'b0, d, bo, ov, lat, bcnt, ba);
        checks++;
        if ({d, bo, ov} !== {8'h7F, 1'b0, 1'b1}) begin errors++; $display("FAIL ovf80_01 got %h/%b/%b required 7f/0/1", d, bo, ov); end
        do_op8(8'h05, 8'h03, 1'b0, d, bo, ov, lat, bcnt, ba);
        checks++;
        if ({d, bo, ov} !== {8'h02, 1'b0, 1'b0}) begin errors++; $display("FAIL ovf05_03 got %h/%b/%b required 02/0/0", d, bo, ov); end
`endif
    endtask

    task automatic test_ignored_start();
        logic [7:0] d, old, xa, xb, got_d; logic bo, ov, ba, xbin, got_bo, stable; int lat, bcnt, dones;
        do_op8(8'hA5, 8'h3C, 1'b0, old, bo, ov, lat, bcnt, ba);
        checks++;
        if (old !== 8'h69) begin errors++; $display("FAIL prev_op got %h required 69", old); end
        xa = 8'($urandom); xb = 8'($urandom); xbin = 1'($urandom_range(0, 1));
        a8 = xa; b8 = xb; bin8 = xbin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0; stable = 1'b1; got_d = 8'hxx; got_bo = 1'bx;
        for (int k = 0; k < 20; k++) begin
            if (done8) begin dones++; got_d = diff8; got_bo = bout8; end
            if (dones == 0 && diff8 !== old) stable = 1'b0;
            if (k == 2 || k == 5 || k == 8) begin
                start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom_range(0, 1));
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL ign_done_count got %0d required 1", dones); end
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL diff_hold got %b required 1", stable); end
        d = 8'(mdl_diff(int'(xa), int'(xb), int'(xbin), 8));
        checks++;
        if ({got_d, got_bo} !== {d, 1'(mdl_bout(int'(xa), int'(xb), int'(xbin)))}) begin
            errors++; $display("FAIL ign_result got %h/%b required %h", got_d, got_bo, d);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] d; logic bo, ov, ba, ovr; int lat, bcnt, dones;
        a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ovr = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovr = ovf8;
`endif
        checks++;
        if ({busy8, done8, diff8, bout8, ovr} !== 12'h000) begin
            errors++; $display("FAIL midrun_rst got busy=%b done=%b diff=%h bout=%b ovf=%b required all 0", busy8, done8, diff8, bout8, ovr);
        end
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL aborted_done got %0d required 0", dones); end
        do_op8(8'h09, 8'h04, 1'b0, d, bo, ov, lat, bcnt, ba);
        checks++;
        if ({d, bo} !== {8'h05, 1'b0}) begin errors++; $display("FAIL after_rst got %h/%b required 05/0", d, bo); end
    endtask

    task automatic test_random8();
        logic [7:0] d, xa, xb; logic bo, ov, ba, xbin; int lat, bcnt;
        for (int i = 0; i < 40; i++) begin
            xa = 8'($urandom); xb = 8'($urandom); xbin = 1'($urandom_range(0, 1));
            do_op8(xa, xb, xbin, d, bo, ov, lat, bcnt, ba);
            checks++;
            if (d !== 8'(mdl_diff(int'(xa), int'(xb), int'(xbin), 8)) || bo !== 1'(mdl_bout(int'(xa), int'(xb), int'(xbin))) || lat !== 8) begin
                errors++; $display("FAIL rand8 a=%h b=%h bin=%b got %h/%b lat=%0d", xa, xb, xbin, d, bo, lat);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (ov !== 1'(mdl_ovf(int'(xa), int'(xb), int'(xbin), 8))) begin
                errors++; $display("FAIL rand8_ovf a=%h b=%h bin=%b got %b", xa, xb, xbin, ov);
            end
`endif
        end
    endtask

    task automatic test_exhaustive4_back_to_back();
        logic [3:0] d; logic bo, ov; int lat;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    do_op4(4'(ia), 4'(ib), 1'(ic), d, bo, ov, lat);
                    checks++;
                    if (d !== 4'(mdl_diff(ia, ib, ic, 4)) || bo !== 1'(mdl_bout(ia, ib, ic))) begin
                        errors++; $display("FAIL ex4 a=%0d b=%0d bin=%0d got %h/%b required %h/%0d", ia, ib, ic, d, bo, mdl_diff(ia, ib, ic, 4), mdl_bout(ia, ib, ic));
                    end
                    checks++;
                    if (lat !== 4) begin errors++; $display("FAIL ex4_lat a=%0d b=%0d got %0d required 4", ia, ib, lat); end
`ifdef SERIAL_SUB_OVF_EN
                    checks++;
                    if (ov !== 1'(mdl_ovf(ia, ib, ic, 4))) begin
                        errors++; $display("FAIL ex4_ovf a=%0d b=%0d bin=%0d got %b", ia, ib, ic, ov);
                    end
`endif
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed8();
        test_ignored_start();
        test_reset_midrun();
        test_random8();
        test_exhaustive4_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing `diff = a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtraction counterpart to the team's ripple full-adder datapath. It serves area-constrained paths where a WIDTH-cycle latency is acceptable. A start/busy/done handshake lets a controller launch one operation at a time.

## Interface
- `WIDTH`, default 8, operand and result width; legal range ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on the accepted start edge.
- `b`  in  WIDTH  subtrahend; captured on the accepted start edge.
- `bin`  in  1  borrow-in; captured on the accepted start edge.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; the result is valid from this cycle onward.
- `diff`  out  WIDTH  registered result.
- `bout`  out  1  final borrow-out (1 means unsigned `a < b + bin`).
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- Reset values: state=IDLE, count=0, shift registers=0, borrow=0; outputs `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0.
- **IDLE** with `start`=1 → RUN on the next edge:
  - load `a` and `b` into shift registers;
  - borrow register ← `bin`;
  - count ← 0.
- **IDLE** with `start`=0: remain in IDLE.
- **RUN**, each cycle:
  - Bit cell on the LSBs: `d = a0 ^ b0 ^ br`; `bnext = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - `d` shifts into the MSB of the working difference register.
  - The a/b shift registers shift right; borrow ← `bnext`; count increments.
- **RUN** with count == WIDTH-1 → DONE:
  - `diff` ← completed working register;
  - `bout` ← final `bnext`.
- **DONE** → IDLE unconditionally; `done`=1 only in this state.
- `start` in RUN or DONE is ignored, not queued.
- `diff`, `bout` and `ovf` hold their last result until the next DONE overwrites them. They do not change during a subsequent RUN.
- Arithmetic is modulo 2^WIDTH. `bin`=1 with `a`=`b` yields all-ones and `bout`=1.
- Counter width is `$clog2(WIDTH)`; it never wraps within an operation.
- `rst` asserted in any state (including mid-RUN) aborts the operation: no `done` pulse, and all registers and outputs return to their reset values on that edge.

## Timing
- Edge E0 accepts `start`. Bit i is processed on edge E(i+1).
- The state is DONE after edge E_WIDTH. `done`, `diff` and `bout` are valid in the cycle following E_WIDTH, i.e. latency = WIDTH cycles from the accepting edge.
- `busy` rises after E0 and falls after E(WIDTH+1).
- Minimum start-to-start period is WIDTH+2 cycles: a new `start` can be accepted on the edge after the DONE cycle.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- **Defined:**
  - Capture sign bits `a[WIDTH-1]` and `b[WIDTH-1]` at load.
  - On entry to DONE: `ovf ← (a_s != b_s) && (d_msb != a_s)`, where `d_msb` is the final computed bit.
  - `ovf` holds its value like `diff`; reset value 0.
- **Undefined:** the `ovf` port, sign registers and logic are absent. All other behaviour is identical.

## Structure
- Package `serial_sub_pkg`:
  - state enum `{IDLE, RUN, DONE}`, 2-bit encoding;
  - a localparam helper for the counter width.
- Sub-module `full_subtractor` (inputs a, b, bin; outputs d, bout), purely combinational. It is instantiated once as the bit cell; all sequencing lives in `serial_subtractor`.

## Test plan
- WIDTH=8, a=0x35, b=0x12, bin=0, one-cycle start → `done` exactly 8 cycles after the accepting edge; diff=0x23, bout=0; `busy` high for 9 cycles.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0.
- With macro defined: a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1. a=0x05, b=0x03 → ovf=0.
- `start` pulsed at RUN cycles 2 and 5 and in DONE → ignored; exactly one `done`; the previous diff remains stable throughout the next RUN until overwritten.
- `rst` asserted at RUN cycle 4 → no `done`; busy, diff, bout and ovf read 0 the next cycle. A fresh start (a=0x09, b=0x04) then yields diff=0x05.
- WIDTH=4, exhaustive over a, b and bin → diff == (a-b-bin) mod 16 and bout == (a < b+bin) on every done; back-to-back starts at the minimum period of 6 cycles.
